// File: rtl/mac_block.sv
// rtl/mac_block.sv - systolic-array multiply-accumulate cell
//
// Purpose:
//   One processing element of a systolic array. Every clock edge it forwards
//   the north operand south and the west operand east through registers, and
//   adds the signed product of the two operands into a 2*WIDTH-bit signed
//   accumulator.
//
// Configuration:
//   BLOCK_SAT_EN  defined   -> accumulator saturates at the signed limits
//                 undefined -> accumulator wraps modulo 2^(2*WIDTH)
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-low reset
//   inp_north  in   WIDTH    signed operand A from the north neighbour
//   inp_west   in   WIDTH    signed operand B from the west neighbour
//   outp_south out  WIDTH    registered inp_north to the south neighbour
//   outp_east  out  WIDTH    registered inp_west to the east neighbour
//   result     out  2*WIDTH  signed accumulator value

module mac_block #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH-1:0]     inp_north,
  input  logic signed [WIDTH-1:0]     inp_west,
  output logic signed [WIDTH-1:0]     outp_south,
  output logic signed [WIDTH-1:0]     outp_east,
  output logic signed [2*WIDTH-1:0]   result
);

  localparam int AW = 2 * WIDTH;

  logic signed [WIDTH-1:0] r_south;
  logic signed [WIDTH-1:0] r_east;
  logic signed [AW-1:0]    r_acc;

  logic signed [AW-1:0]    w_product;
  logic signed [AW-1:0]    w_next_acc;

  // Both operands are signed, so they are sign-extended to the full
  // 2*WIDTH-bit context before multiplying.
  assign w_product = inp_north * inp_west;

`ifdef BLOCK_SAT_EN
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  logic signed [AW:0] w_sum_wide;

  // One guard bit: when it disagrees with the sign bit of the 2*WIDTH
  // result, the true sum is outside the representable range and the guard
  // bit tells which direction it overflowed.
  assign w_sum_wide = {r_acc[AW-1], r_acc} + {w_product[AW-1], w_product};

  always_comb begin
    w_next_acc = w_sum_wide[AW-1:0];
    if (w_sum_wide[AW] != w_sum_wide[AW-1]) begin
      w_next_acc = w_sum_wide[AW] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  // Plain two's-complement add; overflow wraps naturally.
  assign w_next_acc = r_acc + w_product;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_south <= '0;
      r_east  <= '0;
      r_acc   <= '0;
    end else begin
      r_south <= inp_north;
      r_east  <= inp_west;
      r_acc   <= w_next_acc;
    end
  end

  assign outp_south = r_south;
  assign outp_east  = r_east;
  assign result     = r_acc;

endmodule

// File: tb/tb_mac_block.sv
// tb/tb_mac_block.sv - self-checking bench for mac_block

module tb_mac_block;

  logic               clk;
  logic               rst;
  logic signed [15:0] inp_north;
  logic signed [15:0] inp_west;
  logic signed [15:0] outp_south;
  logic signed [15:0] outp_east;
  logic signed [31:0] result;

  int total;
  int bad;

  longint exp_acc;
  longint exp_s;
  longint exp_e;

  mac_block #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .inp_north  (inp_north),
    .inp_west   (inp_west),
    .outp_south (outp_south),
    .outp_east  (outp_east),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference accumulation: exact integer sum, then either clamped to the
  // signed 32-bit range or reduced modulo 2^32.
  function automatic longint acc_model(input longint acc, input longint a, input longint b);
    longint sum;
    longint lo32;
    sum = acc + a * b;
`ifdef BLOCK_SAT_EN
    if (sum > 64'sd2147483647)       return 64'sd2147483647;
    else if (sum < -64'sd2147483648) return -64'sd2147483648;
    else                             return sum;
`else
    lo32 = sum & 64'sh0000_0000_FFFF_FFFF;
    if (lo32 >= 64'sd2147483648) lo32 = lo32 - 64'sd4294967296;
    return lo32;
`endif
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_south"},  outp_south, exp_s);
    check({tag, "_east"},   outp_east,  exp_e);
    check({tag, "_result"}, result,     exp_acc);
  endtask

  task automatic step(input longint a, input longint b, input string tag);
    @(negedge clk);
    inp_north = 16'(a);
    inp_west  = 16'(b);
    @(posedge clk);
    exp_acc = acc_model(exp_acc, a, b);
    exp_s   = a;
    exp_e   = b;
    #1;
    check_all(tag);
  endtask

  // Called 1 time unit after a rising edge: pull reset low between edges,
  // confirm outputs clear before the next edge, release on the falling edge
  // with zero operands so the following edge leaves everything at zero.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    exp_acc = 0;
    exp_s   = 0;
    exp_e   = 0;
    check_all(tag);
    @(negedge clk);
    inp_north = '0;
    inp_west  = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all({tag, "_rel"});
  endtask

  function automatic longint rnd_operand();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return 0;
      1:       return 32767;
      2:       return -32768;
      3:       return longint'($urandom_range(0, 7)) - 4;
      default: return longint'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    total     = 0;
    bad       = 0;
    exp_acc   = 0;
    exp_s     = 0;
    exp_e     = 0;
    rst       = 1'b1;
    inp_north = '0;
    inp_west  = '0;

    // Asynchronous reset between edges, then release.
    #2;
    rst = 1'b0;
    #1;
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_release");

    // Basic accumulation.
    step(5, 3, "acc1");
    check("acc1_val", result, 15);
    step(2, 4, "acc2");
    check("acc2_val", result, 23);
    step(3, 5, "acc3");
    check("acc3_val", result, 38);

    // Signed operands and zero operand.
    step(-1, -1, "neg");
    check("neg_val", result, 39);
    step(0, 10, "zero");
    check("zero_val", result, 39);

    // Mid-operation reset.
    step(7, 8, "pre_rst");
    mid_reset("mid_rst");
    step(-5, -3, "post_rst");
    check("post_rst_val", result, 15);

    // Positive overflow.
    @(posedge clk);
    #1;
    mid_reset("ovf_rst");
    step(32767, 32767, "ovf_a");
    step(32767, 32767, "ovf_b");
    step(32767, 32767, "ovf_c");
`ifdef BLOCK_SAT_EN
    check("ovf_clamp", result, 64'sd2147483647);
`else
    check("ovf_wrap_neg", longint'(result < 0), 1);
`endif
    step(1000, 1000, "ovf_d");

    // Negative overflow.
    @(posedge clk);
    #1;
    mid_reset("unf_rst");
    step(-32768, 32767, "unf_a");
    step(-32768, 32767, "unf_b");
    step(-32768, 32767, "unf_c");
    step(-32768, 32767, "unf_d");

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(rnd_operand(), rnd_operand(), "rand");
      if ($urandom_range(0, 39) == 0) mid_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_block.md
MAC_BLOCK -- requirements
Module: mac_block

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port inp_north, input, WIDTH bits: signed operand A, arriving from the north neighbour.
REQ-005 SHALL have port inp_west, input, WIDTH bits: signed operand B, arriving from the west neighbour.
REQ-006 SHALL have port outp_south, output, WIDTH bits: registered copy of inp_north, driven to the south neighbour.
REQ-007 SHALL have port outp_east, output, WIDTH bits: registered copy of inp_west, driven to the east neighbour.
REQ-008 SHALL have port result, output, 2*WIDTH bits: signed accumulator value.

Function
REQ-009 On each rising clk edge with rst high, outp_south SHALL take the value of inp_north; latency is 1 cycle.
REQ-010 On each rising clk edge with rst high, outp_east SHALL take the value of inp_west; latency is 1 cycle.
REQ-011 On each rising clk edge with rst high, result SHALL become result + (inp_north * inp_west).
REQ-012 The product SHALL be a full 2*WIDTH-bit signed two's-complement product: -5 * -3 = +15 and -1 * -1 = +1.
REQ-013 The accumulation SHALL be signed, 2*WIDTH bits wide, and wrap modulo 2^(2*WIDTH) when BLOCK_SAT_EN is undefined.
REQ-014 The product and the new sum SHALL both use the inputs sampled at the same edge; there is no extra pipeline stage.
REQ-015 A zero operand SHALL leave result unchanged while the pass-through registers still update.
REQ-016 All outputs SHALL be driven directly from registers, with no combinational path from input to output.
REQ-017 The block SHALL have no handshake; every rst-high edge is an active cycle.

Reset
REQ-018 While rst is low, outp_south, outp_east and result SHALL be 0 immediately, without waiting for a clock edge.
REQ-019 If rst is asserted in the middle of accumulation, the accumulated sum SHALL be discarded.
REQ-020 The first rising edge after rst is released SHALL perform a normal update starting from result = 0.

Configuration
REQ-021 The macro BLOCK_SAT_EN SHALL select saturating accumulation when it is defined.
REQ-022 With BLOCK_SAT_EN defined, a positive overflow of the accumulation SHALL clamp result to the maximum signed value, 2^(2W-1)-1.
REQ-023 With BLOCK_SAT_EN defined, a negative overflow SHALL clamp result to the minimum signed value, -2^(2W-1).
REQ-024 Overflow detection SHALL compute the sum one bit wider and compare it against the 2*WIDTH-bit signed range.
REQ-025 Without BLOCK_SAT_EN, result SHALL wrap per REQ-013, and the pass-through behaviour SHALL be identical in both builds.

Verification
REQ-026 Reset: pulse rst low, then release -> outp_south = 0, outp_east = 0, result = 0.
REQ-027 Accumulation: from 0, apply (5,3), then (2,4), then (3,5) on successive edges:
- result = 15, 23, 38
- outp_south / outp_east = 5/3, 2/4, 3/5
REQ-028 Signed operands, continuing from 38:
- apply (-1,-1) -> result = 39
- then (0,10) -> result = 39, outp_south = 0, outp_east = 10
REQ-029 Mid-operation reset: apply (7,8) and assert rst low mid-cycle -> all outputs 0 at once; after release, (-5,-3) -> result = 15, outp_south = -5, outp_east = -3.
REQ-030 Overflow: preload result near the maximum signed value with (32767,32767) products, then add a positive product:
- BLOCK_SAT_EN undefined -> result wraps to a negative value
- BLOCK_SAT_EN defined -> result = 32'h7FFF_FFFF and stays there
REQ-031 Async check: assert rst low between clock edges -> outputs reach 0 before the next rising edge.
